// File: rtl/alu_operand_mux.sv
// Registered ALU operand source select with stall/flush pipeline control,
// sticky out-of-range select flag and a saturating consecutive-stall counter.
module alu_operand_mux #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 2,
    parameter int SELW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]       sel,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic [SELW-1:0]       out_sel,
    output logic                  sel_err,
    output logic [15:0]           stall_cnt
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("alu_operand_mux: WIDTH must be >= 1");
        end
        if (NSRC < 2 || NSRC > 16) begin : g_bad_nsrc
            $error("alu_operand_mux: NSRC must be in 2..16");
        end
        if (SELW != $clog2(NSRC)) begin : g_bad_selw
            $error("alu_operand_mux: SELW must equal clog2(NSRC)");
        end
    endgenerate

    localparam logic [SELW:0] NSRC_L = (SELW+1)'(NSRC);

    logic [WIDTH-1:0] masked [NSRC];
    logic [WIDTH-1:0] sel_data;
    logic             sel_in_range;

    // One-hot masked sources OR'd together; an out-of-range sel matches no
    // source and yields zero without indexing past the array.
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign masked[gi] = (sel == SELW'(gi)) ? in_data[gi*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            sel_data = sel_data | masked[k];
        end
    end

    assign sel_in_range = ({1'b0, sel} < NSRC_L);

    logic [WIDTH-1:0] out_reg,       out_next;
    logic             out_valid_reg, out_valid_next;
    logic [SELW-1:0]  out_sel_reg,   out_sel_next;
    logic             sel_err_reg,   sel_err_next;
    logic [15:0]      stall_cnt_reg, stall_cnt_next;
    logic             err_set;

    assign err_set = !flush && !stall && in_valid && !sel_in_range;

    always_comb begin
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        out_sel_next   = out_sel_reg;
        stall_cnt_next = stall_cnt_reg;
        if (flush) begin
            out_next       = '0;
            out_valid_next = 1'b0;
            out_sel_next   = '0;
            stall_cnt_next = '0;
        end else if (stall) begin
            if (out_valid_reg && stall_cnt_reg != 16'hFFFF) begin
                stall_cnt_next = stall_cnt_reg + 16'd1;
            end
        end else begin
            stall_cnt_next = '0;
            if (in_valid) begin
                out_next       = sel_in_range ? sel_data : '0;
                out_valid_next = 1'b1;
                out_sel_next   = sel;
            end else begin
                out_next       = '0;
                out_valid_next = 1'b0;
                out_sel_next   = '0;
            end
        end
    end

    // A new error in the same cycle as a clear request keeps the flag set.
    always_comb begin
        sel_err_next = err_set | (sel_err_reg & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_sel_reg   <= '0;
            sel_err_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            out_sel_reg   <= out_sel_next;
            sel_err_reg   <= sel_err_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign out_sel   = out_sel_reg;
    assign sel_err   = sel_err_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_alu_operand_mux.sv
// Directed checks of alu_operand_mux: a default 2-source instance and a
// 3-source instance for out-of-range selects.
module tb_alu_operand_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: WIDTH=32, NSRC=2, SELW=1
    logic        rst_n, in_valid, stall, flush, err_clr;
    logic [63:0] in_data;
    logic [0:0]  sel;
    logic [31:0] out;
    logic        out_valid, sel_err;
    logic [0:0]  out_sel;
    logic [15:0] stall_cnt;

    // Three-source instance: WIDTH=8, NSRC=3, SELW=2
    logic        rst3_n, in_valid3, stall3, flush3, err_clr3;
    logic [23:0] in_data3;
    logic [1:0]  sel3;
    logic [7:0]  out3;
    logic        out_valid3, sel_err3;
    logic [1:0]  out_sel3;
    logic [15:0] stall_cnt3;

    int n_checks = 0;
    int n_fail   = 0;
    int n_step   = 0;

    alu_operand_mux u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .stall(stall), .flush(flush), .err_clr(err_clr),
        .out(out), .out_valid(out_valid), .out_sel(out_sel),
        .sel_err(sel_err), .stall_cnt(stall_cnt)
    );

    alu_operand_mux #(.WIDTH(8), .NSRC(3), .SELW(2)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .in_data(in_data3), .sel(sel3),
        .in_valid(in_valid3), .stall(stall3), .flush(flush3), .err_clr(err_clr3),
        .out(out3), .out_valid(out_valid3), .out_sel(out_sel3),
        .sel_err(sel_err3), .stall_cnt(stall_cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        n_step++;
        $display("t=%0t step %0d: out=%h v=%0d sel=%0d err=%0d cnt=%0d | out3=%h v3=%0d sel3=%0d err3=%0d cnt3=%0d",
                 $time, n_step, out, out_valid, out_sel, sel_err, stall_cnt,
                 out3, out_valid3, out_sel3, sel_err3, stall_cnt3);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; err_clr = 1'b0;
        in_data = '0; sel = '0;
        rst3_n = 1'b0; in_valid3 = 1'b0; stall3 = 1'b0; flush3 = 1'b0; err_clr3 = 1'b0;
        in_data3 = '0; sel3 = '0;
        #1;
        step();
        step();
        chk("rst_out", out, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_sel", {31'b0, out_sel}, 32'h0);
        chk("rst_err", {31'b0, sel_err}, 32'h0);
        chk("rst_cnt", {16'b0, stall_cnt}, 32'h0);

        // Legacy 2:1 select
        rst_n = 1'b1; rst3_n = 1'b1;
        in_data = {32'h0000_0010, 32'hDEAD_BEEF}; sel = 1'b0; in_valid = 1'b1;
        step();
        chk("leg_sel0_out", out, 32'hDEAD_BEEF);
        chk("leg_sel0_valid", {31'b0, out_valid}, 32'h1);
        chk("leg_sel0_osel", {31'b0, out_sel}, 32'h0);
        sel = 1'b1;
        step();
        chk("leg_sel1_out", out, 32'h0000_0010);
        chk("leg_sel1_osel", {31'b0, out_sel}, 32'h1);

        // Stall hold while inputs change
        sel = 1'b0;
        step();
        chk("hold_load", out, 32'hDEAD_BEEF);
        stall = 1'b1;
        in_data = {32'hAAAA_AAAA, 32'h5555_5555}; sel = 1'b1;
        step();
        chk("hold_out1", out, 32'hDEAD_BEEF);
        chk("hold_cnt1", {16'b0, stall_cnt}, 32'd1);
        chk("hold_osel1", {31'b0, out_sel}, 32'h0);
        step();
        chk("hold_cnt2", {16'b0, stall_cnt}, 32'd2);
        step();
        chk("hold_out3", out, 32'hDEAD_BEEF);
        chk("hold_cnt3", {16'b0, stall_cnt}, 32'd3);
        stall = 1'b0;
        step();
        chk("release_out", out, 32'hAAAA_AAAA);
        chk("release_cnt", {16'b0, stall_cnt}, 32'd0);
        chk("release_osel", {31'b0, out_sel}, 32'h1);

        // Flush beats stall
        stall = 1'b1;
        step();
        chk("pre_flush_cnt", {16'b0, stall_cnt}, 32'd1);
        flush = 1'b1;
        step();
        chk("flush_out", out, 32'h0);
        chk("flush_valid", {31'b0, out_valid}, 32'h0);
        chk("flush_osel", {31'b0, out_sel}, 32'h0);
        chk("flush_cnt", {16'b0, stall_cnt}, 32'd0);
        flush = 1'b0;
        step();
        chk("stall_invalid_cnt", {16'b0, stall_cnt}, 32'd0);
        stall = 1'b0; in_valid = 1'b0;
        step();
        chk("bubble_out", out, 32'h0);
        chk("bubble_valid", {31'b0, out_valid}, 32'h0);

        // Bad select on the three-source instance
        in_data3 = {8'h33, 8'h22, 8'h11};
        sel3 = 2'd2; in_valid3 = 1'b1;
        step();
        chk("s3_sel2_out", {24'b0, out3}, 32'h33);
        chk("s3_sel2_osel", {30'b0, out_sel3}, 32'd2);
        chk("s3_sel2_err", {31'b0, sel_err3}, 32'h0);
        sel3 = 2'd3;
        step();
        chk("s3_bad_out", {24'b0, out3}, 32'h0);
        chk("s3_bad_valid", {31'b0, out_valid3}, 32'h1);
        chk("s3_bad_osel", {30'b0, out_sel3}, 32'd3);
        chk("s3_bad_err", {31'b0, sel_err3}, 32'h1);
        sel3 = 2'd0; err_clr3 = 1'b1;
        step();
        chk("s3_clr_err", {31'b0, sel_err3}, 32'h0);
        chk("s3_clr_out", {24'b0, out3}, 32'h11);
        sel3 = 2'd3;
        step();
        chk("s3_setwins_err", {31'b0, sel_err3}, 32'h1);
        err_clr3 = 1'b0; sel3 = 2'd1;
        step();
        chk("s3_sticky_err", {31'b0, sel_err3}, 32'h1);
        chk("s3_sel1_out", {24'b0, out3}, 32'h22);

        // Reset mid-stall with sel_err set
        stall3 = 1'b1;
        repeat (5) step();
        chk("s3_cnt5", {16'b0, stall_cnt3}, 32'd5);
        chk("s3_held_out", {24'b0, out3}, 32'h22);
        rst3_n = 1'b0; err_clr3 = 1'b0;
        step();
        chk("s3_rst_out", {24'b0, out3}, 32'h0);
        chk("s3_rst_valid", {31'b0, out_valid3}, 32'h0);
        chk("s3_rst_osel", {30'b0, out_sel3}, 32'h0);
        chk("s3_rst_err", {31'b0, sel_err3}, 32'h0);
        chk("s3_rst_cnt", {16'b0, stall_cnt3}, 32'h0);
        rst3_n = 1'b1; stall3 = 1'b0; sel3 = 2'd2;
        step();
        chk("s3_post_rst_out", {24'b0, out3}, 32'h33);
        chk("s3_post_rst_valid", {31'b0, out_valid3}, 32'h1);
        in_valid3 = 1'b0; sel3 = 2'd3;
        step();
        chk("s3_invalid_err", {31'b0, sel_err3}, 32'h0);
        chk("s3_invalid_osel", {30'b0, out_sel3}, 32'h0);
        chk("s3_invalid_valid", {31'b0, out_valid3}, 32'h0);

        // Stall counter saturation
        in_data = {32'h1234_5678, 32'h0BAD_F00D}; sel = 1'b1; in_valid = 1'b1;
        step();
        chk("sat_load", out, 32'h1234_5678);
        stall = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_cnt_fffe", {16'b0, stall_cnt}, 32'hFFFE);
        step();
        chk("sat_cnt_ffff", {16'b0, stall_cnt}, 32'hFFFF);
        repeat (5) step();
        chk("sat_cnt_hold", {16'b0, stall_cnt}, 32'hFFFF);
        chk("sat_out_hold", out, 32'h1234_5678);
        stall = 1'b0;
        step();
        chk("sat_release_cnt", {16'b0, stall_cnt}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_mux.md
ALU_OPERAND_MUX -- requirements
Module: alu_operand_mux

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range WIDTH >= 1.
REQ-002 Parameter NSRC, default 2, number of selectable sources; legal range 2..16.
REQ-003 Parameter SELW, default 1, select width; SHALL equal ceil(log2(NSRC)), elaboration error otherwise.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_data  input  NSRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH]; source 0 = register read data, source 1 = sign-extended immediate.
REQ-007 sel  input  SELW  source index.
REQ-008 in_valid  input  1  incoming instruction slot is valid.
REQ-009 stall  input  1  hold pipeline register contents.
REQ-010 flush  input  1  replace register contents with a bubble.
REQ-011 err_clr  input  1  clear sticky select error.
REQ-012 out  output  WIDTH  registered selected operand.
REQ-013 out_valid  output  1  out holds a valid operand.
REQ-014 out_sel  output  SELW  registered copy of the select that produced out.
REQ-015 sel_err  output  1  sticky flag: a valid slot used sel >= NSRC.
REQ-016 stall_cnt  output  16  consecutive-stall counter.

Function
REQ-017 All outputs are registered; latency from in_data/sel/in_valid to out/out_valid/out_sel is exactly 1 clk.
REQ-018 Priority per cycle with rst_n=1: flush > stall > advance.
REQ-019 Flush: out <= 0, out_valid <= 0, out_sel <= 0, stall_cnt <= 0; stall ignored that cycle.
REQ-020 Stall (flush=0): out, out_valid, out_sel hold; in_data/sel/in_valid ignored.
REQ-021 Advance (flush=0, stall=0), in_valid=1, sel < NSRC: out <= source sel, out_valid <= 1, out_sel <= sel.
REQ-022 Advance, in_valid=1, sel >= NSRC (only possible when NSRC not a power of 2): out <= 0, out_valid <= 1, out_sel <= sel, sel_err set.
REQ-023 Advance, in_valid=0: out <= 0, out_valid <= 0, out_sel <= 0; sel range not checked.
REQ-024 sel_err set only on an advance cycle with in_valid=1 and sel >= NSRC; stays 1 until cleared.
REQ-025 err_clr=1 clears sel_err the next edge; if a set condition occurs the same cycle, set wins (sel_err stays 1).
REQ-026 stall_cnt increments by 1 on each stall cycle (flush=0) while out_valid=1; saturates at 16'hFFFF.
REQ-027 stall_cnt holds on stall cycles with out_valid=0; clears to 0 on any advance or flush cycle.
REQ-028 NSRC=2, stall=0, flush=0, in_valid=1 SHALL reproduce a registered 2:1 select: sel=0 -> source 0, sel=1 -> source 1.
REQ-029 No combinational path from any input to any output.

Reset
REQ-030 rst_n=0 at a posedge forces out=0, out_valid=0, out_sel=0, sel_err=0, stall_cnt=0, overriding flush, stall, err_clr.
REQ-031 Reset asserted mid-stall discards the held operand; first post-reset advance loads fresh data normally.
REQ-032 Outputs are undefined before the first posedge with rst_n=0; bench applies rst_n=0 for >= 2 cycles.

Verification
REQ-033 Legacy select: WIDTH=32, NSRC=2, in_data={32'h0000_0010, 32'hDEAD_BEEF}, sel=0 then 1, in_valid=1 -> out=32'hDEAD_BEEF then 32'h0000_0010 one cycle after each, out_valid=1.
REQ-034 Stall hold: load 32'hDEAD_BEEF, stall=1 for 3 cycles while in_data changes -> out stays 32'hDEAD_BEEF, stall_cnt = 1,2,3; release -> new operand next cycle, stall_cnt=0.
REQ-035 Flush beats stall: out_valid=1, stall=1 and flush=1 same cycle -> next cycle out=0, out_valid=0, out_sel=0, stall_cnt=0.
REQ-036 Bad select: NSRC=3, SELW=2, sel=3, in_valid=1 -> out=0, out_valid=1, out_sel=3, sel_err=1; err_clr=1 with valid sel -> sel_err=0 next cycle; err_clr=1 with sel=3 again -> sel_err stays 1.
REQ-037 Reset mid-operation: stall_cnt=5, sel_err=1, rst_n=0 one cycle with flush=0, stall=1 -> all outputs 0 next cycle.
REQ-038 Saturation: out_valid=1, stall held 65,540 cycles -> stall_cnt reaches 16'hFFFF and remains there.
